fetch_pc_gen: RTL

Parametrised fetch-PC generator for the out-of-order front end; successor to the single-source program counter. Produces one fetch group per cycle (start PC, per-slot valid mask, redirect epoch) toward the I-cache/fetch stage. It adds a valid/ready handshake, prioritised multi-source redirects, group-alignment of sequential PCs, unaligned-redirect slot masking and a lookahead next-PC for cache indexing.

---
 rtl/fetch_pkg.sv | 34 +++
 rtl/fetch_pc_gen_if.sv | 41 ++++
 rtl/redirect_arb.sv | 48 ++++
 rtl/fetch_pc_gen.sv | 106 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared definitions for the fetch-PC generator: redirect
//               source indices, epoch type, and geometry helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Redirect source indices; lower index wins arbitration.
    localparam int REDIR_COMMIT = 0;
    localparam int REDIR_EXEC   = 1;
    localparam int REDIR_PRED   = 2;

    localparam int EPOCH_W_DFLT = 3;
    typedef logic [EPOCH_W_DFLT-1:0] epoch_t;

    // Bytes covered by one fetch group.
    function automatic int group_bytes(input int core_width, input int insn_bytes);
        return core_width * insn_bytes;
    endfunction

    // Width of the slot-offset field inside a group (0 for single-slot groups).
    function automatic int off_width(input int core_width);
        return (core_width > 1) ? $clog2(core_width) : 0;
    endfunction

    // Width of a redirect source index, never narrower than one bit.
    function automatic int src_width(input int num_redir);
        return (num_redir > 1) ? $clog2(num_redir) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen_if
// Description : Redirect inputs and fetch-group handshake between the PC
//               generator and the fetch stage.
//               master : the PC generator (drives fetch_*, redir_src)
//               slave  : fetch stage / redirect sources
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_gen_if
    import fetch_pkg::*;
#(
    parameter int CORE_WIDTH = 2,
    parameter int XLEN       = 32,
    parameter int NUM_REDIR  = 3,
    parameter int EPOCH_W    = 3
);
    localparam int SRC_W = src_width(NUM_REDIR);

    logic [NUM_REDIR-1:0]      redir_valid;
    logic [NUM_REDIR*XLEN-1:0] redir_addr;
    logic                      fetch_ready;
    logic                      fetch_valid;
    logic [XLEN-1:0]           fetch_pc;
    logic [CORE_WIDTH-1:0]     fetch_mask;
    logic [EPOCH_W-1:0]        fetch_epoch;
    logic [XLEN-1:0]           fetch_npc;
    logic [SRC_W-1:0]          redir_src;

    modport master (
        input  redir_valid, redir_addr, fetch_ready,
        output fetch_valid, fetch_pc, fetch_mask, fetch_epoch, fetch_npc, redir_src
    );

    modport slave (
        output redir_valid, redir_addr, fetch_ready,
        input  fetch_valid, fetch_pc, fetch_mask, fetch_epoch, fetch_npc, redir_src
    );

endinterface
`default_nettype wire

// File: rtl/redirect_arb.sv
`default_nettype none
// ============================================================================
// Module      : redirect_arb
// Description : Fixed-priority redirect arbiter. Lowest-index valid source
//               wins; its target has the sub-instruction bits cleared.
// Ports       : i_valid  - per-source request
//               i_addr   - packed targets, source i at [i*XLEN +: XLEN]
//               o_any    - at least one request present
//               o_idx    - winning source index
//               o_target - sanitised winning target
// Revision    : 1.0 - initial release
// ============================================================================
module redirect_arb
    import fetch_pkg::*;
#(
    parameter int NUM_REDIR  = 3,
    parameter int XLEN       = 32,
    parameter int INSN_BYTES = 4,
    parameter int SRC_W      = src_width(NUM_REDIR)
) (
    input  wire logic [NUM_REDIR-1:0]      i_valid,
    input  wire logic [NUM_REDIR*XLEN-1:0] i_addr,
    output logic                           o_any,
    output logic [SRC_W-1:0]               o_idx,
    output logic [XLEN-1:0]                o_target
);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

    logic [XLEN-1:0] w_raw;

    // Scan from highest to lowest index so the lowest set index is written last.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        w_raw = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (i_valid[i]) begin
                o_any = 1'b1;
                o_idx = SRC_W'(i);
                w_raw = i_addr[i*XLEN +: XLEN];
            end
        end
    end

    assign o_target = w_raw & c_ALIGN_MASK;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Fetch-PC generator. Presents one fetch group per cycle with
//               a per-slot mask and redirect epoch; handles prioritised
//               redirects, group-aligned sequential advance, and provides a
//               combinational lookahead of the next PC.
// Ports       : clk      - clock, rising edge
//               reset_n  - synchronous active-low reset
//               bus      - fetch_pc_gen_if.master (redirect inputs, fetch
//                          handshake, fetch_pc/mask/epoch/npc, redir_src)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int              CORE_WIDTH   = 2,
    parameter int              INSN_BYTES   = 4,
    parameter int              XLEN         = 32,
    parameter int              NUM_REDIR    = 3,
    parameter int              EPOCH_W      = 3,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    fetch_pc_gen_if.master    bus
);
    localparam int              c_GB      = group_bytes(CORE_WIDTH, INSN_BYTES);
    localparam int              c_LOG_IB  = $clog2(INSN_BYTES);
    localparam int              c_SRC_W   = src_width(NUM_REDIR);
    localparam logic [XLEN-1:0] c_GB_MASK = ~XLEN'(c_GB - 1);

    logic [XLEN-1:0]    r_pc;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_valid;

    logic               w_any;
    logic [c_SRC_W-1:0] w_idx;
    logic [XLEN-1:0]    w_target;
    logic [XLEN-1:0]    w_seq_pc;
    logic [XLEN-1:0]    w_npc;

    redirect_arb #(
        .NUM_REDIR  (NUM_REDIR),
        .XLEN       (XLEN),
        .INSN_BYTES (INSN_BYTES),
        .SRC_W      (c_SRC_W)
    ) u_arb (
        .i_valid  (bus.redir_valid),
        .i_addr   (bus.redir_addr),
        .o_any    (w_any),
        .o_idx    (w_idx),
        .o_target (w_target)
    );

    // Sequential successor starts at the next group boundary, which also
    // realigns a group entered via an unaligned redirect. Wraps mod 2^XLEN.
    assign w_seq_pc = (r_pc & c_GB_MASK) + XLEN'(c_GB);

    always_comb begin
        w_npc = r_pc;
        if (!reset_n) begin
            w_npc = RESET_VECTOR;
        end else if (w_any) begin
            w_npc = w_target;
        end else if (r_valid && bus.fetch_ready) begin
            w_npc = w_seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc    <= RESET_VECTOR;
            r_epoch <= '0;
            r_valid <= 1'b0;
        end else begin
            r_pc    <= w_npc;
            r_valid <= 1'b1;
            if (w_any) begin
                r_epoch <= r_epoch + 1'b1;
            end
        end
    end

    // Slots below the entry offset of an unaligned group are not real.
    generate
        if (CORE_WIDTH > 1) begin : g_mask_multi
            localparam int c_OFF_W = off_width(CORE_WIDTH);
            logic [c_OFF_W-1:0] w_off;
            assign w_off = c_OFF_W'(r_pc >> c_LOG_IB);
            for (genvar i = 0; i < CORE_WIDTH; i++) begin : g_slot
                assign bus.fetch_mask[i] = (w_off <= c_OFF_W'(i));
            end
        end else begin : g_mask_single
            assign bus.fetch_mask = 1'b1;
        end
    endgenerate

    assign bus.fetch_valid = r_valid;
    assign bus.fetch_pc    = r_pc;
    assign bus.fetch_epoch = r_epoch;
    assign bus.fetch_npc   = w_npc;
    assign bus.redir_src   = w_idx;

endmodule
`default_nettype wire
